// File: rtl/mac_seq.sv
// -----------------------------------------------------------------------------
// mac_seq -- dot-product sequencer in front of an external multiply-accumulate
// datapath.
//
// The sequencer accepts a job of 'len' element pairs (1..16). It streams each
// accepted pair to the MAC operands and keeps the MAC cleared while idle. After
// the last pair it waits one cycle for the accumulator to settle, then captures
// the sum. The result is held until the consumer takes it.
//
// State machine: IDLE -> RUN -> DRAIN -> DONE -> IDLE
//   IDLE  : MAC held in clear, waiting for start with a non-zero len
//   RUN   : pairs accepted; stall cycles present zero operands to the MAC
//   DRAIN : one cycle; the accumulator is copied into result
//   DONE  : result_valid held until res_ready
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   r          synchronous active-high reset
//   start      one-cycle job request (ignored outside IDLE)
//   len[4:0]   element count 1..16, sampled with start
//   in_valid   element pair valid
//   in_ready   sequencer accepts a pair this cycle
//   in_a/in_b  unsigned 8-bit elements
//   mac_r      clear to the MAC (also high whenever r is high)
//   mac_a/b    MAC operands, zero unless a pair is accepted this cycle
//   mac_acc    16-bit MAC accumulator
//   res_valid  result available
//   res_ready  consumer takes the result
//   result     captured 16-bit dot product
//   busy       high in any state other than IDLE
//   ovf        true sum exceeded 16 bits
//
// Build option:
//   MAC_SEQ_OVF_EN  when defined, a 20-bit shadow sum tracks the exact dot
//                   product and drives ovf. When undefined, ovf is tied low
//                   and no shadow logic exists.
// -----------------------------------------------------------------------------
module mac_seq (
    input  logic        clk,
    input  logic        r,
    input  logic        start,
    input  logic [4:0]  len,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        mac_r,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    input  logic [15:0] mac_acc,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] result,
    output logic        busy,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  len_q;      // job length, frozen for the whole job
    logic [4:0]  cnt_q;      // beats taken so far; 5 bits so that 16 is reachable
    logic [15:0] result_q;

    logic        accept;     // job request taken this cycle
    logic        beat;       // pair transferred this cycle
    logic        last_beat;  // this beat completes the job

    // A zero-length request is dropped here, so IDLE never sees it.
    assign accept    = (state == IDLE) && start && (len != 5'd0);
    // in_ready is high exactly in RUN, so this is in_valid && in_ready.
    assign beat      = (state == RUN) && in_valid;
    assign last_beat = beat && ((cnt_q + 5'd1) == len_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk) begin
        if (r) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = DRAIN;
            DRAIN:                  state_nxt = DONE;
            // start is ignored here, even in the handshake cycle.
            DONE:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        mac_r     = 1'b0;
        mac_a     = 8'd0;
        mac_b     = 8'd0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                mac_r = 1'b1;
                busy  = 1'b0;
            end
            RUN: begin
                in_ready = 1'b1;
                // Operands are zero on stall cycles so the MAC adds nothing.
                if (in_valid) begin
                    mac_a = in_a;
                    mac_b = in_b;
                end
            end
            DRAIN: begin
                // Operands stay zero; the accumulator already holds the sum.
            end
            DONE: begin
                mac_r     = 1'b1;
                res_valid = 1'b1;
            end
            default: begin
                mac_r = 1'b1;
            end
        endcase
        // Reset clears the MAC in the same edge, whatever state we leave.
        if (r) begin
            mac_r = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Job length, beat counter and result capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r) begin
            len_q    <= 5'd0;
            cnt_q    <= 5'd0;
            result_q <= 16'd0;
        end else begin
            // len is sampled only when a job is accepted. Changes to len
            // during the job therefore have no effect.
            if (accept) begin
                len_q <= len;
                cnt_q <= 5'd0;
            end else if (beat) begin
                cnt_q <= cnt_q + 5'd1;
            end
            // The last beat lands in the accumulator on the RUN->DRAIN edge.
            // mac_acc is final during DRAIN.
            if (state == DRAIN) begin
                result_q <= mac_acc;
            end
        end
    end

    assign result = result_q;

    // -------------------------------------------------------------------------
    // Overflow detection
    // -------------------------------------------------------------------------
`ifdef MAC_SEQ_OVF_EN
    // 16 * 255 * 255 = 1,040,400 fits in 20 bits. The shadow sum cannot wrap.
    logic [19:0] shadow_q;
    logic        ovf_q;

    always_ff @(posedge clk) begin
        if (r) begin
            shadow_q <= 20'd0;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                shadow_q <= 20'd0;
            end else if (beat) begin
                shadow_q <= shadow_q + ({12'd0, in_a} * {12'd0, in_b});
            end

            if (state == DRAIN) begin
                ovf_q <= (shadow_q > 20'd65535);
            end else if ((state == DONE) && res_ready) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// -----------------------------------------------------------------------------
// tb_mac_seq -- self-checking bench for mac_seq.
//
// The bench plays the external MAC datapath. It also keeps a job-level model.
// That model tracks a phase, the beats still owed, and the exact integer dot
// product. It derives every output the sequencer should show.
// One negedge process compares the DUT against the model every cycle.
// Directed scenarios also pin the model with hand-computed literals.
// A randomized job loop follows the directed scenarios.
// -----------------------------------------------------------------------------
module tb_mac_seq;

`ifdef MAC_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk;
    logic        r;
    logic        start;
    logic [4:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        mac_r;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [15:0] mac_acc;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] result;
    logic        busy;
    logic        ovf;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [7:0] va [16];
    logic [7:0] vb [16];

    mac_seq dut (
        .clk       (clk),
        .r         (r),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_r     (mac_r),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC: clear on mac_r, otherwise accumulate modulo 2^16.
    always @(posedge clk) begin
        if (mac_r) mac_acc <= 16'd0;
        else       mac_acc <= mac_acc + ({8'd0, mac_a} * {8'd0, mac_b});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Job-level reference model
    // phase: 0 waiting, 1 collecting pairs, 2 settling, 3 offering result
    // ---------------------------------------------------------------------
    int     m_phase  = 0;
    int     m_left   = 0;
    longint m_sum    = 0;
    int     m_result = 0;
    bit     m_ovf    = 1'b0;

    always @(posedge clk) begin
        if (r) begin
            m_phase  = 0;
            m_left   = 0;
            m_result = 0;
            m_ovf    = 1'b0;
        end else begin
            case (m_phase)
                0: if (start && len != 5'd0) begin
                       m_left  = int'(len);
                       m_sum   = 0;
                       m_phase = 1;
                   end
                1: if (in_valid) begin
                       m_sum  += longint'(in_a) * longint'(in_b);
                       m_left -= 1;
                       if (m_left == 0) m_phase = 2;
                   end
                2: begin
                       m_result = int'(m_sum % 65536);
                       m_ovf    = OVF_EN && (m_sum > 65535);
                       m_phase  = 3;
                   end
                default: if (res_ready) begin
                       m_phase = 0;
                       m_ovf   = 1'b0;
                   end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",      busy,      m_phase != 0);
            check("res_valid", res_valid, m_phase == 3);
            check("mac_r",     mac_r,     r || m_phase == 0 || m_phase == 3);
            check("result",    result,    m_result);
            check("ovf",       ovf,       m_ovf);
            if (!r) begin
                check("in_ready", in_ready, m_phase == 1);
                check("mac_a", mac_a, (m_phase == 1 && in_valid) ? in_a : 8'd0);
                check("mac_b", mac_b, (m_phase == 1 && in_valid) ? in_b : 8'd0);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a job up to DONE and leaves it there after 'hold' extra cycles.
    // gap     : idle cycles (in_valid low, garbage data) before each beat
    // poke    : pulse start with random len while the job is in flight
    task automatic run_job(input int n, input int gap, input int hold, input bit poke);
        start    = 1'b1;
        len      = 5'(n);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                len      = 5'($urandom);
                start    = poke && ($urandom_range(0, 1) == 1);
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_a     = va[i];
            in_b     = vb[i];
            len      = 5'($urandom);
            tick();
        end
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        check("drain_no_valid", res_valid, 1'b0);
        check("drain_busy", busy, 1'b1);
        tick();
        check("valid_after_last", res_valid, 1'b1);
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            start     = poke && (h % 2 == 0);
            len       = 5'($urandom_range(1, 16));
            tick();
            start = 1'b0;
            check("hold_in_done", res_valid, 1'b1);
        end
    endtask

    // Handshake out of DONE, optionally with start in the same cycle.
    task automatic finish_job(input bit poke);
        res_ready = 1'b1;
        start     = poke;
        len       = 5'($urandom_range(1, 16));
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check("back_idle", busy, 1'b0);
        check("back_idle_ovf", ovf, 1'b0);
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    initial begin
        r = 1'b1; start = 1'b0; len = 5'd0; in_valid = 1'b0;
        in_a = 8'd0; in_b = 8'd0; res_ready = 1'b0;
        tick();
        tick();
        r = 1'b0;
        chk_en = 1'b1;
        check("reset_busy",   busy,      1'b0);
        check("reset_mac_r",  mac_r,     1'b1);
        check("reset_ready",  in_ready,  1'b0);
        check("reset_valid",  res_valid, 1'b0);
        check("reset_result", result,    16'd0);
        check("reset_ovf",    ovf,       1'b0);

        // Basic job + backpressure: 6*7+5*4+9*2+3*8 = 104.
        va[0] = 8'd6; vb[0] = 8'd7;
        va[1] = 8'd5; vb[1] = 8'd4;
        va[2] = 8'd9; vb[2] = 8'd2;
        va[3] = 8'd3; vb[3] = 8'd8;
        run_job(4, 0, 5, 1'b1);
        check("basic_result", result, 16'd104);
        check("basic_ovf", ovf, 1'b0);
        check("bp_still_done", res_valid, 1'b1);
        finish_job(1'b1);

        // Stalls: 2*7+1*1+10*10 = 115.
        va[0] = 8'd2;  vb[0] = 8'd7;
        va[1] = 8'd1;  vb[1] = 8'd1;
        va[2] = 8'd10; vb[2] = 8'd10;
        run_job(3, 2, 0, 1'b0);
        check("stall_result", result, 16'd115);
        finish_job(1'b0);

        // len = 0 is dropped.
        start = 1'b1; len = 5'd0;
        tick();
        start = 1'b0;
        check("len0_idle", busy, 1'b0);
        tick();
        check("len0_still_idle", busy, 1'b0);

        // len = 16 of (1,1): 16 beats, result 16.
        for (int i = 0; i < 16; i++) begin
            va[i] = 8'd1;
            vb[i] = 8'd1;
        end
        run_job(16, 0, 0, 1'b0);
        check("len16_result", result, 16'd16);
        finish_job(1'b0);

        // Overflow: 2*255*255 = 130050, low 16 bits 64514.
        va[0] = 8'd255; vb[0] = 8'd255;
        va[1] = 8'd255; vb[1] = 8'd255;
        run_job(2, 0, 1, 1'b0);
        check("ovf_result", result, 16'd64514);
        check("ovf_flag", ovf, OVF_EN);
        finish_job(1'b0);

        // Reset after 2 of 4 beats.
        start = 1'b1; len = 5'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        r = 1'b1;
        #1;
        check("rst_mac_r_comb", mac_r, 1'b1);
        tick();
        r = 1'b0;
        check("midrst_busy",   busy,      1'b0);
        check("midrst_mac_r",  mac_r,     1'b1);
        check("midrst_valid",  res_valid, 1'b0);
        check("midrst_ready",  in_ready,  1'b0);
        check("midrst_result", result,    16'd0);
        va[0] = 8'd3; vb[0] = 8'd3;
        run_job(1, 0, 0, 1'b0);
        check("after_rst_result", result, 16'd9);
        finish_job(1'b0);

        // Randomized jobs, checked cycle by cycle against the model.
        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) begin
                va[i] = 8'($urandom);
                vb[i] = 8'($urandom);
            end
            run_job(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
            finish_job($urandom_range(0, 1) == 1);
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock; all state changes on the rising edge.
- r  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a dot product.
- len  in  5  element count, 1..16; sampled with start.
- in_valid  in  1  element pair valid.
- in_ready  out  1  sequencer accepts a pair this cycle.
- in_a  in  8  unsigned element A.
- in_b  in  8  unsigned element B.
- mac_r  out  1  clear to the MAC datapath.
- mac_a  out  8  operand A to the MAC.
- mac_b  out  8  operand B to the MAC.
- mac_acc  in  16  MAC accumulator.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- result  out  16  captured dot product.
- busy  out  1  high in any state other than IDLE.
- ovf  out  1  result exceeded 16 bits; see Configuration.
REQ-003 MAC contract: on each clk edge, mac_r=1 gives acc<=0; otherwise acc<=acc+mac_a*mac_b, truncated to 16 bits.

Function
REQ-004 The FSM SHALL have four states:
- IDLE: mac_r=1, in_ready=0, mac_a=mac_b=0.
- RUN: mac_r=0, in_ready=1.
- DRAIN: mac_r=0, in_ready=0, mac_a=mac_b=0.
- DONE: mac_r=1, in_ready=0, res_valid=1.
REQ-005 IDLE with start=1 and len!=0 SHALL latch len, clear the element counter and go to RUN; start with len=0 SHALL be ignored.
REQ-006 In RUN, a beat SHALL occur when in_valid&&in_ready; on a beat, mac_a=in_a and mac_b=in_b combinationally, and the counter increments.
REQ-007 In RUN without a beat, mac_a=mac_b=0, so stalls add zero.
REQ-008 The beat that makes the count equal the latched len SHALL move RUN to DRAIN on that edge.
REQ-009 DRAIN SHALL last exactly one cycle: result<=mac_acc, then go to DONE. res_valid therefore rises on the edge after the last beat.
REQ-010 In DONE, result SHALL hold stable while res_ready=0; res_valid&&res_ready SHALL go to IDLE on that edge.
REQ-011 start SHALL be ignored outside IDLE, including start coincident with the DONE handshake.
REQ-012 The latched len SHALL NOT change while busy=1; len changes during RUN SHALL have no effect.
REQ-013 The counter SHALL be 5 bits; len=16 SHALL complete after exactly 16 beats, with no wrap.

Reset
REQ-014 r=1 at an edge SHALL force IDLE from any state, including mid-RUN and DONE. After that edge: counter=0, result=0, res_valid=0, busy=0, ovf=0, in_ready=0, mac_r=1.
REQ-015 r SHALL take priority over start, beats and the result handshake in the same cycle.
REQ-016 mac_r SHALL also be driven high combinationally while r=1, whatever the state.

Configuration
REQ-017 Macro MAC_SEQ_OVF_EN defined: the block SHALL keep a 20-bit shadow sum.
- Cleared on entry to RUN.
- Adds in_a*in_b on each beat.
- At the DRAIN edge, ovf<=1 if shadow>65535, else 0.
- ovf holds through DONE and clears on leaving DONE or on reset.
REQ-018 Macro MAC_SEQ_OVF_EN undefined: ovf SHALL be tied to 0 and no shadow logic built; all other behaviour is identical.

Verification
REQ-019 Bench scenarios SHALL include:
- Basic: reset, then start with len=4 and pairs (6,7),(5,4),(9,2),(3,8) with in_valid held high -> result=104, res_valid one edge after the 4th beat, ovf=0.
- Stalls: len=3, pairs (2,7),(1,1),(10,10) with in_valid low for 2 cycles between beats -> mac_a=mac_b=0 during gaps, result=115.
- Backpressure: res_ready low for 5 cycles in DONE, start pulsed -> result stays 104, state stays DONE, start ignored; res_ready=1 -> IDLE next edge.
- Boundary: start with len=0 -> stays IDLE, busy=0. Then len=16, all pairs (1,1) -> exactly 16 beats, result=16.
- Overflow: len=2, pairs (255,255),(255,255) -> result=64514; ovf=1 with MAC_SEQ_OVF_EN, ovf=0 without.
- Reset mid-op: r=1 after 2 of 4 beats -> next edge IDLE, mac_r=1, busy=0, res_valid=0. A new len=1 job (3,3) -> result=9.
